// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
// Contents:
//   DIGIT_W, BCD_MAX, BLANK_NIBBLE  digit width, largest BCD digit, blank code
//   score_state_t                   IDLE / ADD / COMMIT sequencer states
//   bcd_t                           one BCD digit
//   clamp_bcd()                     forces an out-of-range nibble to 9
package score_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} score_state_t;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t clamp_bcd(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_score_counter_digit_add.sv
// Single-digit BCD adder (combinational).
// Ports:
//   i_a, i_b  BCD operands (0..9)
//   i_cin     carry in
//   o_sum     BCD sum digit
//   o_cout    decimal carry out
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_raw;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

  always_comb begin
    o_sum  = w_raw[3:0];
    o_cout = 1'b0;
    if (w_raw > {1'b0, BCD_MAX}) begin
      o_sum  = 4'(w_raw - 5'd10);
      o_cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score accumulator. Points arrive over valid/ready and are
// added one digit per clock into a working copy; the published copy only
// changes at commit, so the display never shows a partial sum.
// Build option: define LEAD_ZERO_BLANK_EN to drive leading zero digits (above
// the most significant non-zero digit, never digit 0) as BLANK_NIBBLE.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   clr_i         synchronous score clear; overrides everything else
//   add_valid_i   points request valid
//   add_ready_o   request can be accepted this cycle
//   pts_bcd_i     points {tens, ones} in BCD
//   digits_o      published score, digit k at [4k+3:4k]
//   done_o        one-cycle pulse when digits_o is updated
//   sat_o         sticky saturation flag (score pinned at all 9s)
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    add_valid_i,
  output logic                    add_ready_o,
  input  logic [7:0]              pts_bcd_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic                    done_o,
  output logic                    sat_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  score_state_t     r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_pts;
  logic             r_carry;
  logic             r_done;
  logic             r_sat;
  logic [3:0]       r_work [NUM_DIGITS];
  logic [3:0]       r_pub  [NUM_DIGITS];

  logic [3:0] w_cur;
  logic [3:0] w_addend;
  logic [3:0] w_sum;
  logic       w_cout;
  logic       w_last;
  logic       w_accept;

  assign add_ready_o = (r_state == IDLE) && !clr_i && !r_sat;
  assign w_accept    = add_valid_i && add_ready_o;
  assign done_o      = r_done;
  assign sat_o       = r_sat;
  assign w_last      = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_cur       = r_work[r_idx];

  // Only the two lowest digits receive points; higher digits just ripple carry.
  always_comb begin
    w_addend = 4'd0;
    if (r_idx == IDX_W'(0)) begin
      w_addend = r_pts[3:0];
    end else if (r_idx == IDX_W'(1)) begin
      w_addend = r_pts[7:4];
    end
  end

  bcd_digit_add u_add (
    .i_a    (w_cur),
    .i_b    (w_addend),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pts   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_work[k] <= '0;
        r_pub[k]  <= '0;
      end
    end else if (clr_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_work[k] <= '0;
        r_pub[k]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pts   <= {clamp_bcd(pts_bcd_i[7:4]), clamp_bcd(pts_bcd_i[3:0])};
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_work[r_idx] <= w_sum;
          r_carry       <= w_cout;
          if (w_last) begin
            r_state <= COMMIT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        COMMIT: begin
          // Carry out of the top digit means the score overflowed: pin at all 9s.
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_carry) begin
              r_work[k] <= BCD_MAX;
              r_pub[k]  <= BCD_MAX;
            end else begin
              r_pub[k] <= r_work[k];
            end
          end
          if (r_carry) begin
            r_sat <= 1'b1;
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
    logic w_seen;
    w_seen   = 1'b0;
    digits_o = '0;
    digits_o[3:0] = r_pub[0];
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (r_pub[k] != 4'd0) begin
        w_seen = 1'b1;
      end
      digits_o[4*k +: 4] = w_seen ? r_pub[k] : BLANK_NIBBLE;
    end
`else
    digits_o = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digits_o[4*k +: 4] = r_pub[k];
    end
`endif
  end

endmodule
